// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair edge counter: synchronises two async oscillator outputs,
// counts their rising edges over a fixed clk window and holds the totals with a valid flag.
module ro_pair_counter #(
  parameter int unsigned WINDOW  = 1000,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ro_a,
  input  logic               ro_b,
  output logic               ro_en,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic [COUNT_W-1:0] count1,
  output logic [COUNT_W-1:0] count2
);

  localparam int unsigned WIN_W = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  state_t             state, state_nx;
  logic [2:0]         sync_a, sync_b;   // [0]=s1, [1]=s2, [2]=s3 history
  logic [1:0]         arm_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic               rise_a, rise_b;
  logic               active_nx;

  assign rise_a    = sync_a[1] & ~sync_a[2];
  assign rise_b    = sync_b[1] & ~sync_b[2];
  assign active_nx = (state_nx == ARM) || (state_nx == COUNT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ARM;
      ARM:     if (arm_cnt == 2'd2) state_nx = COUNT;
      COUNT:   if (win_cnt == WIN_LAST) state_nx = DONE;
      DONE:    if (start) state_nx = ARM;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sync_a  <= '0;
      sync_b  <= '0;
      arm_cnt <= '0;
      win_cnt <= '0;
      ro_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      count1  <= '0;
      count2  <= '0;
    end else begin
      state   <= state_nx;
      sync_a  <= {sync_a[1:0], ro_a};
      sync_b  <= {sync_b[1:0], ro_b};
      arm_cnt <= (state == ARM)   ? arm_cnt + 2'd1      : '0;
      win_cnt <= (state == COUNT) ? win_cnt + WIN_W'(1) : '0;
      // Outputs are registered from the next state so they line up with the state register.
      ro_en   <= active_nx;
      busy    <= active_nx;
      done    <= (state_nx == DONE) && (state != DONE);
      valid   <= (state_nx == DONE);
      if ((state_nx == ARM) && (state != ARM)) begin
        count1 <= '0;
        count2 <= '0;
      end else if (state == COUNT) begin
        if (rise_a && (count1 != '1)) count1 <= count1 + COUNT_W'(1);
        if (rise_b && (count2 != '1)) count2 <= count2 + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ro_pair_counter.sv
// Randomised self-checking bench for ro_pair_counter; two instances cover the
// nominal window and a narrow-counter saturation configuration.
module tb_ro_pair_counter;

  localparam int unsigned W1  = 16;
  localparam int unsigned W2  = 64;
  localparam int unsigned CW2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, a1, b1, start2, a2, b2;
  logic ro_en1, busy1, done1, valid1, ro_en2, busy2, done2, valid2;
  logic [31:0]    c1_1, c2_1;
  logic [CW2-1:0] c1_2, c2_2;

  ro_pair_counter #(.WINDOW(W1), .COUNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ro_a(a1), .ro_b(b1),
    .ro_en(ro_en1), .busy(busy1), .done(done1), .valid(valid1),
    .count1(c1_1), .count2(c2_1)
  );

  ro_pair_counter #(.WINDOW(W2), .COUNT_W(CW2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ro_a(a2), .ro_b(b2),
    .ro_en(ro_en2), .busy(busy2), .done(done2), .valid(valid2),
    .count1(c1_2), .count2(c2_2)
  );

  int checks = 0;
  int errors = 0;
  int cur = 0;

  logic        m_done, m_busy, m_roen, m_valid;
  logic [63:0] m_c1, m_c2;

  always_comb begin
    if (cur == 1) begin
      m_done = done2; m_busy = busy2; m_roen = ro_en2; m_valid = valid2;
      m_c1 = {60'd0, c1_2}; m_c2 = {60'd0, c2_2};
    end else begin
      m_done = done1; m_busy = busy1; m_roen = ro_en1; m_valid = valid1;
      m_c1 = {32'd0, c1_1}; m_c2 = {32'd0, c2_1};
    end
  end

  // Results of the last measurement, filled by the reference model in measure().
  logic [63:0] m_ea, m_eb;
  int          m_done_j, m_pulses, m_busy_err;
  logic        m_valid0;
  logic [63:0] m_cnt0;

  // Pattern modes: 0 const0, 1 const1, 2 toggle each cycle, 3 random, 4 one rise every 4 cycles
  function automatic bit pat(input int mode, input int j, input bit prev);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ~prev;
      3:       return 1'($urandom_range(0, 1));
      4:       return (j % 4) == 2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit na, input bit nb, input bit st);
    @(negedge clk);
    if (cur == 1) begin a2 = na; b2 = nb; start2 = st; end
    else          begin a1 = na; b1 = nb; start1 = st; end
  endtask

  // j counts clock edges after the edge that samples start (j=0). An input rise first
  // sampled at edge j is counted iff 2 <= j <= WINDOW+1; counts saturate at max.
  // mode_b == 5 copies A's waveform onto B.
  task automatic measure(input int sel, input int ma, input int mb, input int extra_j);
    int w;
    logic [63:0] maxc;
    bit pa, pb, na, nb;
    cur  = sel;
    w    = (sel == 1) ? int'(W2) : int'(W1);
    maxc = (sel == 1) ? 64'd15 : 64'hFFFF_FFFF;
    pa   = (sel == 1) ? a2 : a1;
    pb   = (sel == 1) ? b2 : b1;
    m_ea = '0; m_eb = '0; m_done_j = -1; m_pulses = 0; m_busy_err = 0;
    for (int j = 0; j <= w + 8; j++) begin
      na = pat(ma, j, pa);
      nb = (mb == 5) ? na : pat(mb, j, pb);
      drive(na, nb, (j == 0) || (j == extra_j));
      @(posedge clk); #1;
      if (j == 0) begin m_valid0 = m_valid; m_cnt0 = m_c1 | m_c2; end
      if (j >= 2 && j <= w + 1) begin
        if (na && !pa && m_ea < maxc) m_ea++;
        if (nb && !pb && m_eb < maxc) m_eb++;
      end
      if (m_done === 1'b1) begin m_pulses++; if (m_done_j < 0) m_done_j = j; end
      if ((m_busy !== (j <= w + 2)) || (m_roen !== (j <= w + 2))) m_busy_err++;
      pa = na; pb = nb;
    end
    drive(pa, pb, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a1 = ~a1; b1 = ~b1; a2 = ~a2; b2 = ~b2;
      if (i == 2) rst = 1'b0;
      @(posedge clk); #1;
      if (i >= 1) begin
        checks++;
        if ({ro_en1, busy1, done1, valid1, ro_en2, busy2, done2, valid2} !== 8'd0) begin
          errors++;
          $display("FAIL reset_flags cyc%0d got=%b want=00000000", i,
                   {ro_en1, busy1, done1, valid1, ro_en2, busy2, done2, valid2});
        end
        checks++;
        if ((c1_1 !== 32'd0) || (c2_1 !== 32'd0) || (c1_2 !== 4'd0) || (c2_2 !== 4'd0)) begin
          errors++;
          $display("FAIL reset_counts cyc%0d got=%0d/%0d/%0d/%0d want=0", i, c1_1, c2_1, c1_2, c2_2);
        end
      end
    end
  endtask

  // done_j+1 expresses latency with the cycle that presents start as cycle 0.
  task automatic check_result(input string name, input int w);
    checks++;
    if (m_done_j + 1 != w + 4) begin
      errors++; $display("FAIL %s_done_latency got=%0d want=%0d", name, m_done_j + 1, w + 4);
    end
    checks++;
    if (m_pulses != 1) begin
      errors++; $display("FAIL %s_done_pulses got=%0d want=1", name, m_pulses);
    end
    checks++;
    if (m_busy_err != 0) begin
      errors++; $display("FAIL %s_busy_roen got=%0d bad cycles want=0", name, m_busy_err);
    end
    checks++;
    if (m_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid got=%b want=1", name, m_valid);
    end
    checks++;
    if (m_c1 !== m_ea) begin
      errors++; $display("FAIL %s_count1 got=%0d want=%0d", name, m_c1, m_ea);
    end
    checks++;
    if (m_c2 !== m_eb) begin
      errors++; $display("FAIL %s_count2 got=%0d want=%0d", name, m_c2, m_eb);
    end
  endtask

  task automatic test_basic;
    measure(0, 4, 1, -1);
    check_result("basic", W1);
    checks++;
    if (m_c1 !== 64'd4) begin errors++; $display("FAIL basic_count1_abs got=%0d want=4", m_c1); end
  endtask

  task automatic test_simultaneous;
    measure(0, 2, 5, -1);
    check_result("simul", W1);
    checks++;
    if ((m_c1 !== 64'd8) || (m_c2 !== 64'd8)) begin
      errors++; $display("FAIL simul_equal got=%0d/%0d want=8/8", m_c1, m_c2);
    end
  endtask

  task automatic test_saturation;
    measure(1, 2, 0, -1);
    check_result("sat", W2);
    checks++;
    if (m_c1 !== 64'd15) begin errors++; $display("FAIL sat_count1_abs got=%0d want=15", m_c1); end
  endtask

  task automatic test_start_busy;
    measure(0, 3, 3, 10);
    check_result("busy_start", W1);
    measure(0, 3, 5, -1);
    checks++;
    if (m_valid0 !== 1'b0) begin errors++; $display("FAIL restart_valid_drop got=%b want=0", m_valid0); end
    checks++;
    if (m_cnt0 !== 64'd0) begin errors++; $display("FAIL restart_clear got=%0d want=0", m_cnt0); end
    check_result("restart", W1);
  endtask

  task automatic test_reset_mid;
    int pulses;
    cur = 0;
    for (int j = 0; j <= 9; j++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), j == 0);
      if (j == 9) rst = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if ({ro_en1, busy1, done1, valid1} !== 4'd0) begin
      errors++; $display("FAIL midrst_flags got=%b want=0000", {ro_en1, busy1, done1, valid1});
    end
    checks++;
    if ((c1_1 !== 32'd0) || (c2_1 !== 32'd0)) begin
      errors++; $display("FAIL midrst_counts got=%0d/%0d want=0/0", c1_1, c2_1);
    end
    pulses = 0;
    for (int j = 0; j < int'(W1) + 8; j++) begin
      drive(~a1, ~b1, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      if (done1 === 1'b1 || busy1 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midrst_no_done got=%0d active cycles want=0", pulses); end
    measure(0, 3, 3, -1);
    check_result("after_rst", W1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      measure(0, 3, 3, -1);
      check_result("rand_w16", W1);
    end
    for (int k = 0; k < 2; k++) begin
      measure(1, 3, 3, -1);
      check_result("rand_w64", W2);
    end
  endtask

  initial begin
    rst = 1'b0; start1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    start2 = 1'b0; a2 = 1'b1; b2 = 1'b0;
    test_reset;
    test_basic;
    test_simultaneous;
    test_saturation;
    test_start_busy;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_pair_counter.md
# ro_pair_counter

Measurement stage that feeds the PUF comparator. It enables one selected ring-oscillator pair, counts rising edges of both oscillator outputs over a fixed window of system-clock cycles, and presents the two totals as `count1`/`count2`. The totals are held stable with a valid flag until the next measurement. The oscillator outputs arrive pre-divided (each at most clk/2) and asynchronous to `clk`; this block synchronises them and edge-detects them.

## Interface
Parameters:
- `WINDOW`, 1000: measurement window length in `clk` cycles (≥ 1).
- `COUNT_W`, 32: width of each edge counter and of `count1`/`count2`.

Ports:
- `clk`  in  1  system clock. It is the only clock in the block.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a measurement.
- `ro_a`  in  1  oscillator A output (async, pre-divided), counted into `count1`.
- `ro_b`  in  1  oscillator B output (async, pre-divided), counted into `count2`.
- `ro_en`  out  1  oscillator enable. It is high during ARM and COUNT.
- `busy`  out  1  high in ARM and COUNT.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `valid`  out  1  high while `count1`/`count2` hold a completed measurement.
- `count1`  out  COUNT_W  edge total for `ro_a`.
- `count2`  out  COUNT_W  edge total for `ro_b`.

## Operation
- **Synchronisers:** each `ro_x` passes through 2 flops (`s1`, `s2`) plus a history flop `s3`. The rise event is `s2 & ~s3`. These flops run in every state.
- **FSM states:** IDLE, ARM, COUNT, DONE.
- **IDLE:** `ro_en=0`. When `start=1`, go to ARM.
- **ARM:** lasts exactly 3 cycles. Both counters clear on entry. `valid` drops. `ro_en=1`. Rise events are ignored, which flushes start-up glitches through the synchronisers.
- **COUNT:** lasts exactly `WINDOW` cycles, tracked by a window counter of width clog2(WINDOW+1). Each cycle in COUNT with a rise event on A increments `count1`; the same applies to B and `count2`. A and B increment independently, so simultaneous A/B events both count.
- **Saturation:** each counter saturates at 2^COUNT_W−1 and never wraps.
- **Leaving COUNT:** after the last COUNT cycle, go to DONE. `ro_en` falls on DONE entry.
- **DONE:** `done=1` for the entry cycle only. `valid=1` and the counts are frozen. The FSM stays in DONE until `start`, then goes to ARM.
- **`start` in ARM/COUNT:** ignored, with no restart and no queueing.
- **`start` in IDLE/DONE:** accepted on the same cycle it is seen.
- **Reset:** `rst` at any time, including mid-COUNT, forces IDLE on the next edge. It clears both counters, the window counter, and the synchroniser/history flops to 0. It also drives `ro_en`, `busy`, `done` and `valid` to 0.

## Timing
- **Reset values:** `count1=0`, `count2=0`, `valid=0`, `done=0`, `busy=0`, `ro_en=0`, FSM in IDLE.
- **Start latency:** `start` sampled high at edge N puts the FSM in ARM during cycles N+1..N+3 and COUNT during N+4..N+3+WINDOW. DONE is entered at N+4+WINDOW, with `done` and `valid` high from that cycle.
- **Total latency:** `start` to `done` is WINDOW+4 cycles.
- **Edge attribution:** a `ro_x` rising edge set up before clock edge E produces a rise event in cycle E+2. It is counted only if cycle E+2 is a COUNT cycle.
- **Output timing:** all outputs are registered. `count1`/`count2` change only in ARM (clear) and COUNT (increment), and are stable whenever `valid=1`.

## Test plan
- **Reset check:** assert `rst` 2 cycles with `ro_a`/`ro_b` toggling and no `start` → all outputs 0, state IDLE, counts never change.
- **Basic count:** `WINDOW=16`. Drive `ro_a` with rise events landing in COUNT cycles 0,4,8,12 and hold `ro_b` constant 1 → `count1=4`, `count2=0`. `done` pulses exactly 20 cycles after `start`. `valid` stays high.
- **Simultaneous edges and clock-rate toggling:** `WINDOW=16`. Drive A and B with identical edges, both toggling every cycle → `count1=count2=8`. The result feeds the comparator; check the equal-count case there.
- **Saturation:** `COUNT_W=4`, `WINDOW=64`, `ro_a` toggling every cycle → `count1` stops at 15 (no wrap). `ro_b` idle → `count2=0`.
- **Start while busy:** pulse `start` again mid-COUNT → ignored, `done` still at WINDOW+4 from the first start. Then `start` in DONE → `valid` drops at the next edge, counts clear, and a new measurement completes with fresh totals.
- **Reset mid-operation:** assert `rst` during COUNT cycle 5 → next cycle IDLE, `ro_en=0`, counts 0, `valid=0`, and no `done` pulse. A subsequent `start` works normally.
